// File: rtl/gdc_pkg.sv
// rtl/gdc_pkg.sv - shared encodings for the garage-door supervisor
package gdc_pkg;

  // Supervisor sequencing states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_TRAVEL = 3'd3,
    ST_HOLD   = 3'd4,
    ST_FAULT  = 3'd5
  } sup_state_t;

  // Latched fault causes reported on FAULT_CODE
  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_TIMEOUT  = 2'b01;
  localparam logic [1:0] FC_OBSTRUCT = 2'b10;
  localparam logic [1:0] FC_SENSOR   = 2'b11;

  // Motor FSM states, {DN_M, UP_M} as seen by the supervisor
  typedef enum logic [1:0] {
    MOT_STOP = 2'b00,
    MOT_UP   = 2'b01,
    MOT_DOWN = 2'b10
  } motor_state_t;

  // Cycles allowed between entering WAIT and seeing the motor move
  localparam int WAIT_WINDOW = 2;

  // Counter width for a count of n; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gdc_debounce.sv
// rtl/gdc_debounce.sv - button debouncer with registered level and rise pulse
module gdc_debounce
  import gdc_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = cnt_width(DEB_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  // Consecutive-high sample count; stops at CNT_LAST so it never wraps
  logic [CW-1:0] cnt;

  // Level rises on the DEB_CYC-th consecutive high sample, drops on any low sample
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else if (!din) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else if (level) begin
      rise <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      level <= 1'b1;
      rise  <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      rise <= 1'b0;
    end
  end

endmodule

// File: rtl/gdc_supervisor.sv
// rtl/gdc_supervisor.sv - request arbitration and fault supervision for the door motor FSM
module gdc_supervisor
  import gdc_pkg::*;
#(
  parameter int DEB_CYC        = 4,
  parameter int TRAVEL_TMO_CYC = 4096,
  parameter int AUTO_CLOSE_CYC = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN_WALL,
  input  logic       BTN_REMOTE,
  input  logic       OBSTRUCT,
  input  logic       AC_EN,
  input  logic       FAULT_CLR,
  input  logic       UP_Max,
  input  logic       DN_Max,
  input  logic       UP_M,
  input  logic       DN_M,
  output logic       Activate,
  output logic       FAULT,
  output logic [1:0] FAULT_CODE,
  output logic       BUSY,
  output logic       AC_PEND
);

  localparam int TW = cnt_width(TRAVEL_TMO_CYC);
  localparam int HW = cnt_width(AUTO_CLOSE_CYC);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TMO_CYC - 1);
  localparam logic [HW-1:0] HOLD_LOAD   = HW'(AUTO_CLOSE_CYC - 1);
  localparam logic          WAIT_LAST   = 1'(WAIT_WINDOW - 1);

  logic wall_level, wall_rise;
  logic remote_level, remote_rise;
  logic req;

  sup_state_t    state, state_nxt;
  logic [1:0]    code_nxt;
  logic [TW-1:0] travel_cnt, travel_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          wait_cnt, wait_nxt;

  gdc_debounce #(.DEB_CYC(DEB_CYC)) u_deb_wall (
    .CLK   (CLK),
    .RST   (RST),
    .din   (BTN_WALL),
    .level (wall_level),
    .rise  (wall_rise)
  );

  gdc_debounce #(.DEB_CYC(DEB_CYC)) u_deb_remote (
    .CLK   (CLK),
    .RST   (RST),
    .din   (BTN_REMOTE),
    .level (remote_level),
    .rise  (remote_rise)
  );

  // Request is the rising edge of the ORed debounced buttons: simultaneous presses,
  // or one button pressed while the other is already held, give a single request
  always_comb begin
    req = (wall_rise | remote_rise)
        & ~(wall_level & ~wall_rise)
        & ~(remote_level & ~remote_rise);
  end

  // Next-state and counter decisions, with faults ahead of normal progress
  always_comb begin
    state_nxt  = state;
    code_nxt   = FAULT_CODE;
    travel_nxt = travel_cnt;
    hold_nxt   = hold_cnt;
    wait_nxt   = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (UP_Max & DN_Max) begin
            state_nxt = ST_FAULT;
            code_nxt  = FC_SENSOR;
          end else if (UP_Max ^ DN_Max) begin
            state_nxt = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        state_nxt = ST_WAIT;
        wait_nxt  = 1'b0;
      end
      ST_WAIT: begin
        if (UP_M | DN_M) begin
          state_nxt  = ST_TRAVEL;
          travel_nxt = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_SENSOR;
        end else begin
          wait_nxt = 1'b1;
        end
      end
      ST_TRAVEL: begin
        if (travel_cnt != TRAVEL_LAST) begin
          travel_nxt = travel_cnt + 1'b1;
        end
        if (OBSTRUCT & DN_M) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_OBSTRUCT;
        end else if (travel_cnt == TRAVEL_LAST) begin
          state_nxt = ST_FAULT;
          code_nxt  = FC_TIMEOUT;
        end else if (!UP_M && !DN_M) begin
          if (UP_Max & AC_EN) begin
            state_nxt = ST_HOLD;
            hold_nxt  = HOLD_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (!AC_EN || !UP_Max) begin
          state_nxt = ST_IDLE;
        end else if (req) begin
          state_nxt = ST_ISSUE;
        end else if (OBSTRUCT) begin
          hold_nxt = HOLD_LOAD;
        end else if (hold_cnt == '0) begin
          state_nxt = ST_ISSUE;
        end else begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end
      ST_FAULT: begin
        if (FAULT_CLR) begin
          state_nxt = ST_IDLE;
          code_nxt  = FC_NONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and outputs all registered from the next-state decision
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      travel_cnt <= '0;
      hold_cnt   <= '0;
      wait_cnt   <= 1'b0;
      Activate   <= 1'b0;
      FAULT      <= 1'b0;
      FAULT_CODE <= FC_NONE;
      BUSY       <= 1'b0;
      AC_PEND    <= 1'b0;
    end else begin
      state      <= state_nxt;
      travel_cnt <= travel_nxt;
      hold_cnt   <= hold_nxt;
      wait_cnt   <= wait_nxt;
      Activate   <= (state_nxt == ST_ISSUE);
      FAULT      <= (state_nxt == ST_FAULT);
      FAULT_CODE <= code_nxt;
      BUSY       <= (state_nxt inside {ST_ISSUE, ST_WAIT, ST_TRAVEL});
      AC_PEND    <= (state_nxt == ST_HOLD);
    end
  end

endmodule

// File: tb/tb_gdc_supervisor.sv
// tb/tb_gdc_supervisor.sv - self-checking bench for gdc_supervisor with a door motor model
module tb_gdc_supervisor;
  import gdc_pkg::*;

  localparam int DEB = 4;
  localparam int TMO = 64;
  localparam int ACC = 32;
  localparam int MODE_NORM  = 0;
  localparam int MODE_DEAF  = 1;
  localparam int MODE_STALL = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       BTN_WALL = 1'b0, BTN_REMOTE = 1'b0, OBSTRUCT = 1'b0, AC_EN = 1'b0, FAULT_CLR = 1'b0;
  logic       UP_Max, DN_Max;
  logic       Activate, FAULT, BUSY, AC_PEND;
  logic [1:0] FAULT_CODE;

  logic up_m, dn_m, at_top, at_bot;
  int   steps;
  logic init_top = 1'b0;
  logic both_lim = 1'b0;
  int   mot_mode = MODE_NORM;
  int   travel_len = 20;

  int errors = 0, checks = 0;
  int cyc, act_cnt, act_first, act_last, busy_cnt, pend_cnt, pend_first, fault_first, dn_first;
  int wall_left = 0, remote_left = 0, obs_left = 0, clr_left = 0;

  always #5 CLK = ~CLK;

  assign UP_Max = at_top | both_lim;
  assign DN_Max = at_bot | both_lim;

  gdc_supervisor #(.DEB_CYC(DEB), .TRAVEL_TMO_CYC(TMO), .AUTO_CLOSE_CYC(ACC)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BTN_WALL   (BTN_WALL),
    .BTN_REMOTE (BTN_REMOTE),
    .OBSTRUCT   (OBSTRUCT),
    .AC_EN      (AC_EN),
    .FAULT_CLR  (FAULT_CLR),
    .UP_Max     (UP_Max),
    .DN_Max     (DN_Max),
    .UP_M       (up_m),
    .DN_M       (dn_m),
    .Activate   (Activate),
    .FAULT      (FAULT),
    .FAULT_CODE (FAULT_CODE),
    .BUSY       (BUSY),
    .AC_PEND    (AC_PEND)
  );

  // Motor: registers Activate, runs travel_len cycles to the limit, stops the cycle after it
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      up_m <= 1'b0; dn_m <= 1'b0; steps <= 0;
      at_top <= init_top; at_bot <= !init_top;
    end else if (up_m) begin
      if (at_top) up_m <= 1'b0;
      else begin
        steps <= steps + 1;
        if (mot_mode != MODE_STALL && steps == travel_len - 1) at_top <= 1'b1;
      end
    end else if (dn_m) begin
      if (at_bot) dn_m <= 1'b0;
      else begin
        steps <= steps + 1;
        if (mot_mode != MODE_STALL && steps == travel_len - 1) at_bot <= 1'b1;
      end
    end else if (Activate && mot_mode != MODE_DEAF) begin
      if (at_bot) begin up_m <= 1'b1; at_bot <= 1'b0; steps <= 0; end
      else if (at_top) begin dn_m <= 1'b1; at_top <= 1'b0; steps <= 0; end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    cyc = 0; act_cnt = 0; act_first = -1; act_last = -1; busy_cnt = 0;
    pend_cnt = 0; pend_first = -1; fault_first = -1; dn_first = -1;
  endtask

  task automatic press(input bit w, input bit r, input int hold);
    if (w) begin BTN_WALL = 1'b1; wall_left = hold; end
    if (r) begin BTN_REMOTE = 1'b1; remote_left = hold; end
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      cyc++;
      if (Activate) begin
        act_cnt++;
        if (act_first < 0) act_first = cyc;
        act_last = cyc;
      end
      if (BUSY) busy_cnt++;
      if (AC_PEND) begin
        pend_cnt++;
        if (pend_first < 0) pend_first = cyc;
      end
      if (FAULT && fault_first < 0) fault_first = cyc;
      if (dn_m && dn_first < 0) dn_first = cyc;
      if (wall_left > 0) begin wall_left--; if (wall_left == 0) BTN_WALL = 1'b0; end
      if (remote_left > 0) begin remote_left--; if (remote_left == 0) BTN_REMOTE = 1'b0; end
      if (obs_left > 0) begin obs_left--; if (obs_left == 0) OBSTRUCT = 1'b0; end
      if (clr_left > 0) begin clr_left--; if (clr_left == 0) FAULT_CLR = 1'b0; end
    end
  endtask

  task automatic do_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    int k, g1, g2;
    bit w;
    #2 RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_activate", int'(Activate), 0);
    check("rst_fault", int'(FAULT), 0);
    check("rst_code", int'(FAULT_CODE), 0);
    check("rst_busy", int'(BUSY), 0);
    check("rst_ac_pend", int'(AC_PEND), 0);
    RST = 1'b1;
    @(negedge CLK);

    // Open from closed, no auto-close
    travel_len = 20;
    clear_stats(); press(1, 0, DEB); observe(40);
    check("open_act_cnt", act_cnt, 1);
    check("open_act_lat", act_first, DEB + 1);
    check("open_busy_cycles", busy_cnt, travel_len + 3);
    check("open_idle_busy", int'(BUSY), 0);

    // Random travel lengths and buttons, alternating direction
    for (int r = 0; r < 3; r++) begin
      travel_len = $urandom_range(6, 30);
      w = 1'($urandom_range(0, 1));
      clear_stats(); press(w, !w, DEB + $urandom_range(0, 3)); observe(travel_len + 14);
      check("rnd_act_cnt", act_cnt, 1);
      check("rnd_act_lat", act_first, DEB + 1);
      check("rnd_busy_cycles", busy_cnt, travel_len + 3);
    end

    // Auto-close: open, hold ACC cycles, then close
    travel_len = 20; AC_EN = 1'b1;
    clear_stats(); press(1, 0, DEB); observe(110);
    check("ac_act_cnt", act_cnt, 2);
    check("ac_pend_first", pend_first, DEB + 1 + travel_len + 3);
    check("ac_pend_cycles", pend_cnt, ACC);
    check("ac_act_last", act_last, DEB + 1 + travel_len + 3 + ACC);
    check("ac_busy_cycles", busy_cnt, 2 * (travel_len + 3));

    // Button press during HOLD pre-empts the countdown
    for (int r = 0; r < 2; r++) begin
      k = (r == 0) ? 17 : int'($urandom_range(0, 26));
      clear_stats(); press(1, 0, DEB);
      for (int i = 0; i < 80 && pend_first < 0; i++) observe(1);
      check("hp_pend_first", pend_first, DEB + 1 + travel_len + 3);
      observe(k); press(1, 0, DEB); observe(40);
      check("hp_pend_cycles", pend_cnt, k + DEB + 1);
      check("hp_act_last", act_last, pend_first + k + DEB + 1);
    end

    // Obstruction during HOLD reloads the countdown
    k = $urandom_range(0, 20);
    clear_stats(); press(1, 0, DEB);
    for (int i = 0; i < 80 && pend_first < 0; i++) observe(1);
    observe(k); OBSTRUCT = 1'b1; obs_left = 1; observe(70);
    check("ho_pend_cycles", pend_cnt, k + 1 + ACC);
    check("ho_act_last", act_last, pend_first + k + 1 + ACC);
    AC_EN = 1'b0;

    // Short presses never reach the debounce threshold
    for (int r = 0; r < 2; r++) begin
      g1 = (r == 0) ? 3 : int'($urandom_range(1, DEB - 1));
      g2 = (r == 0) ? 3 : int'($urandom_range(1, DEB - 1));
      clear_stats(); press(1, 0, g1); observe(g1 + 1); press(1, 0, g2); observe(g2 + 8);
      check("glitch_no_act", act_cnt, 0);
    end

    // Simultaneous wall and remote give one request
    clear_stats(); press(1, 1, DEB + 2); observe(40);
    check("both_btn_act_cnt", act_cnt, 1);
    check("both_btn_lat", act_first, DEB + 1);

    // Obstruction while closing faults next cycle; presses ignored until clear
    clear_stats(); press(1, 0, DEB);
    for (int i = 0; i < 20 && dn_first < 0; i++) observe(1);
    observe(3); OBSTRUCT = 1'b1; obs_left = 1; observe(1);
    check("obs_fault", int'(FAULT), 1);
    check("obs_code", int'(FAULT_CODE), int'(FC_OBSTRUCT));
    press(1, 0, DEB); observe(12);
    check("obs_press_ignored", act_cnt, 1);
    check("obs_code_held", int'(FAULT_CODE), int'(FC_OBSTRUCT));
    FAULT_CLR = 1'b1; clr_left = 1; observe(1);
    check("obs_clr_fault", int'(FAULT), 0);
    check("obs_clr_code", int'(FAULT_CODE), 0);
    check("obs_clr_busy", int'(BUSY), 0);
    observe(30);
    clear_stats(); press(1, 0, DEB); observe(40);
    check("obs_idle_act_lat", act_first, DEB + 1);

    // Motor never completes travel: timeout fault
    mot_mode = MODE_STALL;
    clear_stats(); press(1, 0, DEB); observe(90);
    check("tmo_act_cnt", act_cnt, 1);
    check("tmo_latency", fault_first - act_first, TMO + 2);
    check("tmo_code", int'(FAULT_CODE), int'(FC_TIMEOUT));
    FAULT_CLR = 1'b1; clr_left = 1; observe(1);
    check("tmo_clr_code", int'(FAULT_CODE), 0);
    mot_mode = MODE_NORM;
    do_reset();

    // Reset mid-travel clears outputs asynchronously, then normal operation resumes
    clear_stats(); press(1, 0, DEB); observe(12);
    check("rt_busy_before", int'(BUSY), 1);
    RST = 1'b0;
    #1;
    check("rt_async_outputs", int'({Activate, FAULT, FAULT_CODE, BUSY, AC_PEND}), 0);
    @(negedge CLK); RST = 1'b1;
    observe(3);
    check("rt_after_busy", int'(BUSY), 0);
    check("rt_after_fault", int'(FAULT), 0);
    clear_stats(); press(1, 0, DEB); observe(40);
    check("rt_act_lat", act_first, DEB + 1);
    check("rt_busy_cycles", busy_cnt, travel_len + 3);

    // Motor ignoring Activate: no-start fault
    mot_mode = MODE_DEAF;
    clear_stats(); press(1, 0, DEB); observe(20);
    check("deaf_act_cnt", act_cnt, 1);
    check("deaf_latency", fault_first - act_first, 3);
    check("deaf_code", int'(FAULT_CODE), int'(FC_SENSOR));
    FAULT_CLR = 1'b1; clr_left = 1; observe(1);
    mot_mode = MODE_NORM;

    // Both limits active with a press: sensor fault, no Activate
    both_lim = 1'b1;
    clear_stats(); press(1, 0, DEB); observe(15);
    check("lim_act_cnt", act_cnt, 0);
    check("lim_fault_first", fault_first, DEB + 1);
    check("lim_code", int'(FAULT_CODE), int'(FC_SENSOR));
    FAULT_CLR = 1'b1; clr_left = 1; observe(1);
    both_lim = 1'b0;
    check("lim_clr_fault", int'(FAULT), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
